reg_stream_sink: RTL and testbench

- Terminating end of an EN/R-qualified register pipeline: absorbs the last stage's R/D stream into a small FIFO.
- Generates the pipeline-wide EN (stall) signal so no item is ever lost.
- Re-presents the data to a downstream consumer as a valid/ready stream.
- Sits at the tail of every EN-stalled datapath built from the team's pipeline register stages.

---
 rtl/reg_stream_sink_pkg.sv | 19 +
 rtl/reg_stream_sink_if.sv | 25 ++
 rtl/reg_stream_fifo_mem.sv | 27 ++
 rtl/reg_stream_sink.sv | 85 ++++++++
 tb/tb_reg_stream_sink.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/reg_stream_sink_pkg.sv
// reg_stream_pkg: shared constants and helpers for the reg_stream sink slice.
//   clog2      - constant ceil(log2) used to size pointers and counters
//   DATA_W     - default pipeline data width
//   FIFO_DEPTH - default sink FIFO depth
//   PTR_W      - pointer width for the default depth
package reg_stream_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = clog2(FIFO_DEPTH);

endpackage

// File: rtl/reg_stream_sink_if.sv
// reg_stream_sink_if: pipeline-tail and valid/ready signals of the stream sink.
//   R_IN, D_IN  - valid flag and data from the last pipeline stage
//   EN_OUT      - pipeline-wide advance enable back to the upstream stages
//   M_VALID     - head of FIFO holds data
//   M_DATA      - head data (show-ahead)
//   M_READY     - consumer accepts the head this cycle
//   COUNT       - current occupancy
//   slave modport is the sink, master modport is the producer/consumer side.
interface reg_stream_sink_if
    import reg_stream_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
);
    logic                   R_IN;
    logic [N-1:0]           D_IN;
    logic                   EN_OUT;
    logic                   M_VALID;
    logic [N-1:0]           M_DATA;
    logic                   M_READY;
    logic [clog2(DEPTH):0]  COUNT;

    modport slave  (input R_IN, D_IN, M_READY, output EN_OUT, M_VALID, M_DATA, COUNT);
    modport master (output R_IN, D_IN, M_READY, input EN_OUT, M_VALID, M_DATA, COUNT);
endinterface

// File: rtl/reg_stream_fifo_mem.sv
// reg_stream_fifo_mem: DEPTH x N register array, one write port, async read, no reset.
//   CLK          - clock
//   we/waddr/wdata - synchronous write port
//   raddr/rdata  - combinational read port
module reg_stream_fifo_mem
    import reg_stream_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = PTR_W
)
(
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);
    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/reg_stream_sink.sv
// reg_stream_sink: tail of an EN-stalled register pipeline; buffers R/D into a FIFO,
// drives the pipeline EN so nothing is lost, and re-presents data as valid/ready.
//   CLK, RST   - clock, synchronous active-high reset
//   s          - reg_stream_sink_if.slave (R_IN, D_IN, EN_OUT, M_VALID, M_DATA, M_READY, COUNT)
//   STALL_CNT  - saturating count of cycles with R_IN=1 and EN_OUT=0; exists only
//                when REG_STREAM_SINK_STATS_EN is defined (together with CNT_W)
module reg_stream_sink
    import reg_stream_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
`ifdef REG_STREAM_SINK_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
)
(
    input logic CLK,
    input logic RST,
    reg_stream_sink_if.slave s
`ifdef REG_STREAM_SINK_STATS_EN
    ,
    output logic [CNT_W-1:0] STALL_CNT
`endif
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          en_q, en_d, push, pop;

    // EN is registered from next occupancy: a pop at full reopens EN only one
    // cycle later, which keeps M_READY off any combinational path to EN_OUT.
    always_comb begin
        push     = s.R_IN & en_q;
        pop      = (count_q != '0) & s.M_READY;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        en_d     = count_d != CW'(DEPTH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            en_q     <= en_d;
        end
    end

    assign s.EN_OUT  = en_q;
    assign s.M_VALID = count_q != '0;
    assign s.COUNT   = count_q;

    reg_stream_fifo_mem #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (s.D_IN),
        .raddr (rd_ptr_q),
        .rdata (s.M_DATA)
    );

`ifdef REG_STREAM_SINK_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = (s.R_IN & ~en_q & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign STALL_CNT = stall_cnt_q;
`endif
endmodule

// File: tb/tb_reg_stream_sink.sv
// tb_reg_stream_sink: directed + random check of reg_stream_sink against a queue model.
module tb_reg_stream_sink;
    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    reg_stream_sink_if #(.N(N), .DEPTH(DEPTH)) sif ();

`ifdef REG_STREAM_SINK_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    reg_stream_sink #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .s(sif.slave), .STALL_CNT(stall_cnt));
`else
    reg_stream_sink #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .s(sif.slave));
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [N-1:0] q[$];
    logic [N-1:0] got[$];
    logic         en_m = 1'b0;
    longint       stall_m = 0;
    logic         acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_count"}, 64'(sif.COUNT), 64'(q.size()));
        chk({tag, "_valid"}, 64'(sif.M_VALID), 64'(q.size() != 0));
        chk({tag, "_en"}, 64'(sif.EN_OUT), 64'(en_m));
        if (q.size() != 0) chk({tag, "_data"}, 64'(sif.M_DATA), 64'(q[0]));
`ifdef REG_STREAM_SINK_STATS_EN
        chk({tag, "_stall"}, 64'(stall_cnt), 64'(stall_m));
`endif
    endtask

    // One clock: drive, advance the queue model on the edge, then check #1 later.
    task automatic step(input string tag, input logic r, input logic [N-1:0] d,
                        input logic rdy, output logic accepted);
        sif.R_IN = r;
        sif.D_IN = d;
        sif.M_READY = rdy;
        accepted = r && en_m && !RST;
        @(posedge CLK);
        if (RST) begin
            q.delete();
            en_m = 1'b0;
            stall_m = 0;
        end else begin
            if (r && !en_m && stall_m < (64'd1 << CNT_W) - 1) stall_m++;
            if (q.size() != 0 && rdy) got.push_back(q.pop_front());
            if (r && en_m) q.push_back(d);
            en_m = q.size() != DEPTH;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [N-1:0] v;
        int guard;
        sif.R_IN = 1'b0;
        sif.D_IN = '0;
        sif.M_READY = 1'b0;

        // Reset hold and release
        for (int i = 0; i < 3; i++) step("rst", 1'b0, '0, 1'b0, acc);
        chk("rst_en_low", 64'(sif.EN_OUT), 64'd0);
        RST = 1'b0;
        step("release", 1'b0, '0, 1'b0, acc);
        chk("release_en", 64'(sif.EN_OUT), 64'd1);
        chk("release_count", 64'(sif.COUNT), 64'd0);

        // Fill without draining
        v = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            step("fill", 1'b1, v, 1'b0, acc);
            if (acc) v++;
        end
        chk("fill_count", 64'(sif.COUNT), 64'd4);
        chk("fill_en", 64'(sif.EN_OUT), 64'd0);
        chk("fill_head", 64'(sif.M_DATA), 64'h0001);
        chk("fill_held", 64'(v), 64'h0005);
`ifdef REG_STREAM_SINK_STATS_EN
        chk("fill_stall", 64'(stall_cnt), 64'd2);
`endif

        // Drain from full, upstream keeps offering 5 and 6
        got.delete();
        step("drain0", 1'b1, v, 1'b1, acc);
        chk("drain_en_after_pop", 64'(sif.EN_OUT), 64'd1);
        guard = 0;
        while ((v <= 16'h0006 || q.size() != 0) && guard < 40) begin
            step("drain", v <= 16'h0006, v, 1'b1, acc);
            if (acc) v++;
            guard++;
        end
        chk("drain_bound", 64'(guard < 40), 64'd1);
        chk("drain_total", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk("drain_order", 64'(got[i]), 64'(i + 1));

        // Steady stream
        got.delete();
        for (int i = 0; i < 20; i++) step("stream", 1'b1, N'(16'h0100 + i), 1'b1, acc);
        chk("stream_count", 64'(sif.COUNT), 64'd1);
        chk("stream_en", 64'(sif.EN_OUT), 64'd1);
        chk("stream_out", 64'(got.size()), 64'd19);
        if (got.size() != 0) chk("stream_last", 64'(got[got.size() - 1]), 64'h0112);

        // Random backpressure
        v = 16'h1000;
        for (int i = 0; i < 1000; i++) begin
            step("rand", 1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)), acc);
            chk("rand_le_depth", 64'(sif.COUNT <= DEPTH), 64'd1);
            if (acc) v++;
        end

        // Reset mid-operation with three entries held
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            step("pre_drain", 1'b0, '0, 1'b1, acc);
            guard++;
        end
        for (int i = 0; i < 3; i++) step("load3", 1'b1, N'(16'h0050 + i), 1'b0, acc);
        chk("mid_count3", 64'(sif.COUNT), 64'd3);
        RST = 1'b1;
        step("mid_rst", 1'b0, '0, 1'b0, acc);
        chk("mid_rst_count", 64'(sif.COUNT), 64'd0);
        chk("mid_rst_en", 64'(sif.EN_OUT), 64'd0);
        RST = 1'b0;
        step("mid_release", 1'b0, '0, 1'b0, acc);
        chk("mid_release_en", 64'(sif.EN_OUT), 64'd1);
        step("push_aa", 1'b1, 16'h00AA, 1'b0, acc);
        chk("first_after_rst", 64'(sif.M_DATA), 64'h00AA);
        chk("first_after_rst_valid", 64'(sif.M_VALID), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
